// File: rtl/line_burst_adaptor.sv
// Cache-line to burst-bus adaptor: each 256-bit line read or write from the arbiter
// becomes one burst of BEATS narrow beats on the physical-memory bus, lowest slot first.
`timescale 1ns/1ps
module line_burst_adaptor #(
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  line_read_i,
   input  logic                  line_write_i,
   input  logic [ADDR_WIDTH-1:0] line_addr_i,
   input  logic [LINE_WIDTH-1:0] line_wdata_i,
   output logic [LINE_WIDTH-1:0] line_rdata_o,
   output logic                  line_resp_o,
   input  logic [BEAT_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [BEAT_WIDTH-1:0] pmem_wdata
);

   localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W       = $clog2(BEATS);
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t                  state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [LINE_WIDTH-1:0]   wline_r;
   logic [ADDR_WIDTH-1:0]   aligned_addr_s;
   logic                    unused_addr_s;

   // Byte offset within the line is dropped; the burst always starts on a line boundary.
   assign aligned_addr_s = {line_addr_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign unused_addr_s  = ^line_addr_i[OFFSET_BITS-1:0];

   // Current write beat is selected straight from the latched line by the beat counter.
   assign pmem_wdata = wline_r[cnt_r*BEAT_WIDTH +: BEAT_WIDTH];

   // Burst sequencer: request capture, beat counting, read assembly and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         wline_r      <= {LINE_WIDTH{1'b0}};
         line_rdata_o <= {LINE_WIDTH{1'b0}};
         line_resp_o  <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= {ADDR_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               line_resp_o <= 1'b0;
               if (line_read_i) begin
                  pmem_address <= aligned_addr_s;
                  cnt_r        <= {CNT_W{1'b0}};
                  pmem_read    <= 1'b1;
                  pmem_write   <= 1'b0;
                  state_r      <= RD_BURST;
               end else if (line_write_i) begin
                  pmem_address <= aligned_addr_s;
                  wline_r      <= line_wdata_i;
                  cnt_r        <= {CNT_W{1'b0}};
                  pmem_read    <= 1'b0;
                  pmem_write   <= 1'b1;
                  state_r      <= WR_BURST;
               end else begin
                  pmem_read    <= 1'b0;
                  pmem_write   <= 1'b0;
               end
            end
            RD_BURST: begin
               if (pmem_resp) begin
                  line_rdata_o[cnt_r*BEAT_WIDTH +: BEAT_WIDTH] <= pmem_rdata;
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (cnt_r == LAST_BEAT) begin
                     pmem_read   <= 1'b0;
                     line_resp_o <= 1'b1;
                     state_r     <= DONE;
                  end
               end
            end
            WR_BURST: begin
               if (pmem_resp) begin
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (cnt_r == LAST_BEAT) begin
                     pmem_write  <= 1'b0;
                     line_resp_o <= 1'b1;
                     state_r     <= DONE;
                  end
               end
            end
            DONE: begin
               // Held requests are deliberately not sampled here so they are not re-issued.
               line_resp_o <= 1'b0;
               pmem_read   <= 1'b0;
               pmem_write  <= 1'b0;
               state_r     <= IDLE;
            end
            default: begin
               line_resp_o <= 1'b0;
               pmem_read   <= 1'b0;
               pmem_write  <= 1'b0;
               cnt_r       <= {CNT_W{1'b0}};
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench for line_burst_adaptor: the bench plays arbiter and memory,
// queues expected lines/beats when requesting and pops them as the DUT produces them.
`timescale 1ns/1ps
module tb_line_burst_adaptor;

   logic         clk;
   logic         rst;
   logic         line_read_i;
   logic         line_write_i;
   logic [31:0]  line_addr_i;
   logic [255:0] line_wdata_i;
   logic [255:0] line_rdata_o;
   logic         line_resp_o;
   logic [63:0]  pmem_rdata;
   logic         pmem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [63:0]  pmem_wdata;

   int total = 0;
   int bad   = 0;

   logic [255:0] exp_line_q[$];
   logic [63:0]  exp_beat_q[$];
   logic [255:0] last_rline = 256'd0;

   line_burst_adaptor dut (
      .clk          (clk),
      .rst          (rst),
      .line_read_i  (line_read_i),
      .line_write_i (line_write_i),
      .line_addr_i  (line_addr_i),
      .line_wdata_i (line_wdata_i),
      .line_rdata_o (line_rdata_o),
      .line_resp_o  (line_resp_o),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // One arbiter transaction. stall_mode=1: memory answers only on even cycles.
   // abort_at>0: pulse reset once that many read beats have been accepted.
   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rline,
                          input int stall_mode, input int abort_at);
      logic [31:0] exp_addr;
      int n, bi, stalls;
      bit done, go;
      exp_addr = {addr[31:5], 5'b00000};
      n = 0; bi = 0; stalls = 0; done = 1'b0;
      if (rd) exp_line_q.push_back(rline);
      else for (int i = 0; i < 4; i++) exp_beat_q.push_back(wline[i*64 +: 64]);
      line_read_i  = rd;
      line_write_i = wr;
      line_addr_i  = addr;
      line_wdata_i = wline;
      @(posedge clk);
      while (!done) begin
         @(negedge clk);
         n++;
         pmem_resp = 1'b0;
         if (n > 60) begin
            check("timeout", 256'd0, 256'd1);
            done = 1'b1;
         end else if (abort_at > 0 && bi == abort_at) begin
            rst = 1'b1;
            #1;
            check("rst_outs", {line_resp_o, pmem_read, pmem_write, pmem_address, pmem_wdata}, 256'd0);
            check("rst_rdata", line_rdata_o, 256'd0);
            line_read_i  = 1'b0;
            line_write_i = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("no_resp_after_abort", {line_resp_o, pmem_read, pmem_write}, 256'd0);
            end
            if (rd && exp_line_q.size() > 0) void'(exp_line_q.pop_back());
            last_rline = 256'd0;
            done = 1'b1;
         end else if (line_resp_o) begin
            check("latency", n, 5 + stalls);
            check("resp_bus_idle", {pmem_read, pmem_write}, 256'd0);
            check("beats_used", bi, 4);
            if (rd) begin
               if (exp_line_q.size() == 0) check("sb_empty", 256'd0, 256'd1);
               else check("rdata", line_rdata_o, exp_line_q.pop_front());
               last_rline = rline;
            end else begin
               check("rdata_kept", line_rdata_o, last_rline);
               check("wbeats_left", exp_beat_q.size(), 0);
            end
            // Request is still held here; DONE must not re-issue it.
            @(negedge clk);
            check("resp_pulse", {line_resp_o, pmem_read, pmem_write}, 256'd0);
            line_read_i  = 1'b0;
            line_write_i = 1'b0;
            done = 1'b1;
         end else begin
            check("addr", pmem_address, exp_addr);
            if (rd) check("rd_only", {pmem_read, pmem_write}, 256'd2);
            else    check("wr_only", {pmem_read, pmem_write}, 256'd1);
            if (!rd) begin
               if (exp_beat_q.size() == 0) check("wbeat_extra", 256'd0, 256'd1);
               else check("wbeat", pmem_wdata, exp_beat_q[0]);
            end
            go = (stall_mode == 0) || (n % 2 == 0);
            if (go && bi < 4) begin
               pmem_resp = 1'b1;
               if (rd) pmem_rdata = rline[bi*64 +: 64];
               else if (exp_beat_q.size() > 0) void'(exp_beat_q.pop_front());
               bi++;
            end else begin
               stalls++;
               pmem_rdata = {$urandom, $urandom};
            end
         end
      end
      pmem_resp = 1'b0;
   endtask

   initial begin
      logic [255:0] l0, l1;
      rst = 1'b1;
      line_read_i = 1'b0; line_write_i = 1'b0; line_addr_i = 32'd0;
      line_wdata_i = 256'd0; pmem_rdata = 64'd0; pmem_resp = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("idle_outs", {line_resp_o, pmem_read, pmem_write, pmem_address, pmem_wdata}, 256'd0);
         check("idle_rdata", line_rdata_o, 256'd0);
      end

      l0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      run_txn(1'b1, 1'b0, 32'h0000_104C, 256'd0, l0, 0, 0);

      l1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      run_txn(1'b0, 1'b1, 32'h0000_2000, l1, 256'd0, 1, 0);

      run_txn(1'b1, 1'b1, 32'h0000_0080, rand_line(), rand_line(), 0, 0);

      run_txn(1'b1, 1'b0, 32'h0000_3010, 256'd0, rand_line(), 0, 2);
      run_txn(1'b1, 1'b0, 32'h0000_3010, 256'd0, rand_line(), 0, 0);

      run_txn(1'b1, 1'b0, 32'h0000_4000, 256'd0, rand_line(), 1, 0);
      run_txn(1'b0, 1'b1, 32'h0000_5020, rand_line(), 256'd0, 0, 0);

      for (int t = 0; t < 6; t++) begin
         if ($urandom_range(0, 1) == 1)
            run_txn(1'b1, 1'b0, $urandom, 256'd0, rand_line(), $urandom_range(0, 1), 0);
         else
            run_txn(1'b0, 1'b1, $urandom, rand_line(), 256'd0, $urandom_range(0, 1), 0);
      end

      check("sb_lines_drained", exp_line_q.size(), 0);
      check("sb_beats_drained", exp_beat_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
Bridges the 256-bit cache-line port of the memory arbiter to the 64-bit burst physical-memory bus. Each line read or write becomes one 4-beat burst. Read beats are assembled into a full line. Write lines are split into beats, sent lowest-address beat first. The block sits directly downstream of the arbiter, between the cache subsystem and physical memory.

Parameters:
LINE_WIDTH, 256, cache line width in bits.
BEAT_WIDTH, 64, memory bus width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH (4).
ADDR_WIDTH, 32, address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
line_read_i  in  1  line read request from arbiter, held until line_resp_o.
line_write_i  in  1  line write request from arbiter, held until line_resp_o.
line_addr_i  in  ADDR_WIDTH  line address; low log2(LINE_WIDTH/8) bits ignored.
line_wdata_i  in  LINE_WIDTH  write line.
line_rdata_o  out  LINE_WIDTH  assembled read line.
line_resp_o  out  1  one-cycle completion pulse.
pmem_rdata  in  BEAT_WIDTH  read beat from memory.
pmem_resp  in  1  beat accepted/valid (one per beat).
pmem_read  out  1  burst read request.
pmem_write  out  1  burst write request.
pmem_address  out  ADDR_WIDTH  line-aligned burst address.
pmem_wdata  out  BEAT_WIDTH  current write beat.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values: state IDLE, beat counter 0, line_resp_o 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, line_rdata_o 0.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - line_read_i=1 → latch aligned address (low 5 bits forced 0), clear counter, go RD_BURST.
  - Otherwise line_write_i=1 → latch address and line_wdata_i, go WR_BURST.
  - Read has priority if both are asserted; the write is ignored. The arbiter must never assert both.
- RD_BURST:
  - pmem_read=1; pmem_address holds the latched address.
  - Each cycle with pmem_resp=1: pmem_rdata is stored into line slot [counter*64 +: 64] and the counter increments.
  - On the beat with counter=3, go DONE.
  - pmem_resp=0 cycles are stalls: counter and data are unchanged, and pmem_read stays asserted.
- WR_BURST:
  - pmem_write=1; pmem_wdata = latched line slot [counter*64 +: 64], combinational from the counter.
  - Each pmem_resp=1 advances the counter; after the counter=3 beat, go DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle; pmem_read and pmem_write are 0; go IDLE.
  - Requests are not sampled in DONE, so a held request is not re-issued. The arbiter drops its request on seeing line_resp_o.
- line_rdata_o holds the last assembled line until the next read burst starts overwriting it. It is unchanged by writes.
- Latency: request high at edge k (in IDLE) → pmem_read/pmem_write high after edge k. With back-to-back beats at edges k+1..k+4, line_resp_o is high between edges k+4 and k+5. Minimum is 5 cycles request-to-resp. Each stall cycle adds 1.
- Counter is 2 bits; it wraps to 0 on the last beat and is never observed at a wrapped value.
- pmem_resp outside RD_BURST/WR_BURST is ignored.
- Reset asserted mid-burst: immediate return to reset values. The in-flight burst is abandoned and no line_resp_o is produced. Memory must tolerate a dropped request.
- Unaligned line_addr_i: aligned silently; no error.

Test Plan:
- Reset then idle 10 cycles → all outputs 0, no pmem_read/pmem_write.
- Read, addr 0x0000_104C, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → pmem_address=0x0000_1040; line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; line_resp_o pulses once, 5 cycles after request.
- Write, addr 0x0000_2000, line_wdata_i = {D,C,B,A} 64-bit words, pmem_resp on every other cycle → pmem_wdata shows A,B,C,D in order, each held through its stall cycle; pmem_write held until the 4th resp; one line_resp_o.
- line_read_i and line_write_i asserted together at addr 0x80 → read burst only, pmem_write never asserted.
- Reset pulsed after 2 read beats → outputs return to 0 immediately, no line_resp_o. A new read then completes correctly, with counter restarting at slot 0.
- Read then write back-to-back (arbiter re-requests the cycle after resp) → write starts from IDLE; line_rdata_o is unchanged by the write.
